// File: rtl/spectrum_pkg.sv
// Shared sizing, state encoding and result record for the spectrum peak detector.
package spectrum_pkg;
  localparam int NF = 11;              // frequency bins
  localparam int DW = 32;              // signed bin data width
  localparam int PW = 2 * DW;          // unsigned power width
  localparam int BW = $clog2(NF);

  typedef logic [BW-1:0] bin_idx_t;

  typedef enum logic [1:0] {COLLECT, SCAN, HOLD} state_e;

  typedef struct packed {
    bin_idx_t          peak_bin;
    logic [PW-1:0]     peak_pow;
    logic [NF-1:0]     bin_mask;
  } result_t;
endpackage

// File: rtl/spectrum_peak_detector_if.sv
// Bank-side inputs plus the result record handshake toward the register readout.
interface spectrum_peak_detector_if;
  import spectrum_pkg::*;
  logic [NF-1:0]         valid_i;
  logic [NF-1:0][DW-1:0] data_i;
  logic [PW-1:0]         thr_i;
  logic                  res_valid;
  logic                  res_ready;
  bin_idx_t              peak_bin;
  logic [PW-1:0]         peak_pow;
  logic [NF-1:0]         bin_mask;
  logic                  overrun;

  modport master (output valid_i, data_i, thr_i, res_ready,
                  input  res_valid, peak_bin, peak_pow, bin_mask, overrun);
  modport slave  (input  valid_i, data_i, thr_i, res_ready,
                  output res_valid, peak_bin, peak_pow, bin_mask, overrun);
endinterface

// File: rtl/spectrum_peak_detector_abs_square.sv
// Two-stage signed-to-power pipeline: |x| registered, then |x|^2 registered.
// The magnitude is kept unsigned in DW bits so |-2^(DW-1)| = 2^(DW-1) stays exact.
module abs_square
  import spectrum_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x_i,
  output logic [PW-1:0] sq_o
);
  logic [DW-1:0] mag_q, mag_d;
  logic [PW-1:0] sq_q, sq_d;

  // Magnitude of the incoming sample and square of the registered magnitude.
  always_comb begin
    mag_d = x_i[DW-1] ? (~x_i + DW'(1)) : x_i;
    sq_d  = {{DW{1'b0}}, mag_q} * {{DW{1'b0}}, mag_q};
  end

  // Pipeline registers; cleared so a reset mid-scan leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      sq_q  <= '0;
    end else begin
      mag_q <= mag_d;
      sq_q  <= sq_d;
    end
  end

  assign sq_o = sq_q;
endmodule

// File: rtl/spectrum_peak_detector.sv
// Captures one result per bin, squares them through a shared pipeline, and
// publishes the strongest bin plus a threshold mask as one record per frame.
module spectrum_peak_detector
  import spectrum_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  spectrum_peak_detector_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int CW     = $clog2(NF + 2);
  // Last bin issues at NF-1 and retires two cycles later.
  localparam logic [CW-1:0] LAST_CNT = CW'(NF + 1);

  state_e                state_q, state_d;
  logic [NF-1:0]         valid_q, got_q, got_d, rise;
  logic [NF-1:0][DW-1:0] buf_q, buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         thr_q;
  result_t               res_q, res_d;
  logic                  overrun_q;
  logic [STAGES:1]       vld_q;
  logic [STAGES:1][BW-1:0] idx_q;
  logic                  issue, scan_entry;
  bin_idx_t              issue_idx;
  logic [DW-1:0]         issue_data;
  logic [PW-1:0]         sq;

  assign rise       = bus.valid_i & ~valid_q;
  assign scan_entry = (state_q == COLLECT) && (&got_q);
  assign issue      = (state_q == SCAN) && (cnt_q < CW'(NF));
  assign issue_idx  = bin_idx_t'(cnt_q);

  // Frame sequencing: collect all bins, scan them, hold until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (&got_q)             state_d = SCAN;
      SCAN:    if (cnt_q == LAST_CNT)  state_d = HOLD;
      HOLD:    if (bus.res_ready)      state_d = COLLECT;
      default:                         state_d = COLLECT;
    endcase
  end

  // Capture buffer, scan counter, issue mux and peak/mask accumulation.
  always_comb begin
    got_d      = got_q;
    buf_d      = buf_q;
    cnt_d      = '0;
    res_d      = res_q;
    issue_data = '0;
    if (state_q == COLLECT) begin
      for (int k = 0; k < NF; k++) begin
        if (rise[k]) begin
          buf_d[k] = bus.data_i[k];
          got_d[k] = 1'b1;
        end
      end
    end
    if (state_q == HOLD && bus.res_ready) got_d = '0;
    if (state_q == SCAN) cnt_d = cnt_q + CW'(1);
    for (int k = 0; k < NF; k++) begin
      if (issue_idx == bin_idx_t'(k)) issue_data = buf_q[k];
    end
    if (scan_entry) res_d = '0;
    if (vld_q[STAGES]) begin
      // Bin 0 seeds the peak; strict > keeps the lower index on ties.
      if (idx_q[STAGES] == '0 || sq > res_q.peak_pow) begin
        res_d.peak_bin = idx_q[STAGES];
        res_d.peak_pow = sq;
      end
      for (int k = 0; k < NF; k++) begin
        if (idx_q[STAGES] == bin_idx_t'(k)) res_d.bin_mask[k] = (sq > thr_q);
      end
    end
  end

  abs_square u_abs_square (
    .clk  (clk),
    .rst  (rst),
    .x_i  (issue_data),
    .sq_o (sq)
  );

  // State, frame data and the valid/index shift alongside the square pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      valid_q   <= '0;
      got_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      thr_q     <= '0;
      res_q     <= '0;
      overrun_q <= 1'b0;
      vld_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= bus.valid_i;
      got_q     <= got_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      if (scan_entry) thr_q <= bus.thr_i;
      overrun_q <= overrun_q | ((|rise) && (state_q != COLLECT));
      vld_q     <= {vld_q[1], issue};
      idx_q     <= {idx_q[1], issue_idx};
    end
  end

  assign bus.res_valid = (state_q == HOLD);
  assign bus.peak_bin  = res_q.peak_bin;
  assign bus.peak_pow  = res_q.peak_pow;
  assign bus.bin_mask  = res_q.bin_mask;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_spectrum_peak_detector.sv
// Directed bench for spectrum_peak_detector with a frame-level reference model.
module tb_spectrum_peak_detector;
  import spectrum_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectrum_peak_detector_if bus();
  spectrum_peak_detector dut (.clk(clk), .rst(rst), .bus(bus));

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase 0 collecting, 1 scanning (fixed latency), 2 holding a record.
  int                     m_phase = 0, m_cnt = 0;
  logic [NF-1:0]          m_prev = '0, m_got = '0;
  logic signed [DW-1:0]   m_buf [NF];
  logic [PW-1:0]          m_thr = '0;
  logic                   e_valid = 1'b0, e_ovr = 1'b0;
  logic [BW-1:0]          e_bin = '0;
  logic [PW-1:0]          e_pow = '0;
  logic [NF-1:0]          e_mask = '0;
  bit                     run = 1'b0;

  function automatic logic [PW-1:0] pw(input logic signed [DW-1:0] x);
    longint v;
    longint unsigned a;
    v = longint'(x);
    a = (v < 0) ? longint'(-v) : v;
    return a * a;
  endfunction

  task automatic model_results();
    logic [PW-1:0] p;
    e_bin  = '0;
    e_pow  = pw(m_buf[0]);
    e_mask = '0;
    for (int k = 0; k < NF; k++) begin
      p = pw(m_buf[k]);
      if (p > e_pow) begin e_bin = BW'(k); e_pow = p; end
      if (p > m_thr) e_mask[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [NF-1:0] r;
    logic full;
    if (rst) begin
      m_phase = 0; m_got = '0; m_prev = '0;
      e_valid = 0; e_ovr = 0; e_bin = '0; e_pow = '0; e_mask = '0;
      return;
    end
    r = bus.valid_i & ~m_prev;
    m_prev = bus.valid_i;
    case (m_phase)
      0: begin
        full = &m_got;
        for (int k = 0; k < NF; k++)
          if (r[k]) begin m_buf[k] = bus.data_i[k]; m_got[k] = 1'b1; end
        if (full) begin m_phase = 1; m_cnt = 0; m_thr = bus.thr_i; end
      end
      1: begin
        if (|r) e_ovr = 1'b1;
        m_cnt++;
        if (m_cnt == NF + 2) begin m_phase = 2; e_valid = 1'b1; model_results(); end
      end
      default: begin
        if (|r) e_ovr = 1'b1;
        if (bus.res_ready) begin m_phase = 0; m_got = '0; e_valid = 1'b0; end
      end
    endcase
  endtask

  // Every cycle: compare DUT against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("res_valid", bus.res_valid, e_valid);
        chk("overrun", bus.overrun, e_ovr);
        if (m_phase != 1) begin
          chk("peak_bin", bus.peak_bin, e_bin);
          chk("peak_pow", bus.peak_pow, e_pow);
          chk("bin_mask", bus.bin_mask, e_mask);
        end
        model_step();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drop_all();
    @(posedge clk); #1;
    bus.valid_i = '0;
  endtask

  task automatic raise_all(input logic [NF-1:0][DW-1:0] d, input logic [PW-1:0] thr);
    @(posedge clk); #1;
    bus.data_i  = d;
    bus.thr_i   = thr;
    bus.valid_i = '1;
  endtask

  // Counts negedges until res_valid; after raise_all the rise edge is count 2.
  task automatic wait_res(output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid) seen = 1'b1;
    end
    if (!seen) chk("res_timeout", 64'd0, 64'd1);
  endtask

  task automatic accept();
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [BW-1:0] b,
                            input logic [PW-1:0] p, input logic [NF-1:0] m);
    chk({name, ".valid"}, bus.res_valid, 1'b1);
    chk({name, ".bin"},   bus.peak_bin, b);
    chk({name, ".pow"},   bus.peak_pow, p);
    chk({name, ".mask"},  bus.bin_mask, m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [NF-1:0][DW-1:0] d;
    int lat, nrec;
    rst = 1'b1;
    bus.valid_i = '0; bus.data_i = '0; bus.thr_i = '0; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", bus.res_valid, 1'b0);
    chk("rst.bin", bus.peak_bin, 0);
    chk("rst.pow", bus.peak_pow, 0);
    chk("rst.mask", bus.bin_mask, 0);
    chk("rst.ovr", bus.overrun, 1'b0);

    // Most negative input: magnitude 2^31 squares exactly to 2^62.
    d = '0; d[0] = 32'h8000_0000;
    raise_all(d, 64'd0);
    wait_res(lat);
    expect_res("minneg", 0, 64'h4000_0000_0000_0000, 11'h001);
    accept();

    // k*100 with bin 7 = -5000, thr 10^6: only bin 7 is strictly above
    // (bin 10 lands exactly on 10^6 and is excluded by strict >).
    drop_all();
    for (int k = 0; k < NF; k++) d[k] = DW'(k * 100);
    d[7] = DW'(-5000);
    raise_all(d, 64'd1_000_000);
    wait_res(lat);
    chk("latency", 64'(lat - 2), 64'd14);
    expect_res("allrise", 7, 64'd25_000_000, 11'h080);
    accept();

    // Staggered rises; equal maxima on bins 3 and 9 -> lower index wins.
    drop_all();
    for (int k = 0; k < NF; k++) d[k] = DW'(k + 1);
    d[3] = 32'h7FFF_FFFF; d[9] = 32'h7FFF_FFFF;
    bus.data_i = d;
    bus.thr_i  = 64'h3FFF_FFFF_0000_0000;
    for (int k = 0; k < NF; k++) begin
      @(posedge clk); #1;
      bus.valid_i[k] = 1'b1;
      repeat (2) @(posedge clk);
    end
    wait_res(lat);
    expect_res("tie", 3, 64'h3FFF_FFFF_0000_0001, 11'h208);
    accept();

    // Held record while bin 2 toggles: stable outputs, overrun sets.
    drop_all();
    for (int k = 0; k < NF; k++) d[k] = DW'(-(k * 10));
    raise_all(d, 64'd50);
    wait_res(lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.valid_i[2] = ~bus.valid_i[2];
    end
    @(negedge clk);
    expect_res("hold", 10, 64'd10_000, 11'h7FE);
    chk("hold.ovr", bus.overrun, 1'b1);
    accept();
    // Valids still high after acceptance: no new frame must start.
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("norecap.valid", bus.res_valid, 1'b0);

    // Reset in S4 discards the scan and clears the sticky overrun.
    drop_all();
    for (int k = 0; k < NF; k++) d[k] = DW'(k * 100 + 1);
    raise_all(d, 64'd1_000_000);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; bus.valid_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.valid", bus.res_valid, 1'b0);
    chk("midrst.bin", bus.peak_bin, 0);
    chk("midrst.pow", bus.peak_pow, 0);
    chk("midrst.mask", bus.bin_mask, 0);
    chk("midrst.ovr", bus.overrun, 1'b0);

    // Fresh frame after reset; other bins sit exactly on the threshold.
    for (int k = 0; k < NF; k++) d[k] = DW'(7);
    d[5] = DW'(-300);
    raise_all(d, 64'd49);
    wait_res(lat);
    expect_res("fresh", 5, 64'd90_000, 11'h020);
    accept();

    // Back-to-back frames with res_ready held high.
    nrec = 0;
    bus.res_ready = 1'b1;
    drop_all();
    for (int k = 0; k < NF; k++) d[k] = DW'(1000);
    raise_all(d, 64'd999_999);
    wait_res(lat);
    if (bus.res_valid) nrec++;
    expect_res("b2b.a", 0, 64'd1_000_000, 11'h7FF);
    drop_all();
    for (int k = 0; k < NF; k++) d[k] = DW'(3 * k);
    raise_all(d, 64'd100);
    wait_res(lat);
    if (bus.res_valid) nrec++;
    expect_res("b2b.b", 10, 64'd900, 11'h7F0);
    chk("b2b.records", 64'(nrec), 64'd2);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
